bcd_counter4: RTL and testbench

BCD_COUNTER4 -- requirements
Module: bcd_counter4

---
 rtl/bcd_counter4_pkg.sv | 24 ++
 rtl/bcd_digit.sv | 47 ++++
 rtl/bcd_counter4.sv | 112 +++++++++++
 tb/tb_bcd_counter4.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter4_pkg.sv
// Shared BCD definitions for the counter and the display path.
// Also provides the packed-BCD legality check applied to MAX_COUNT.
package bcd_counter4_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned NUM_DIGITS = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX_DIGIT = 4'd9;

    // True when every nibble of a packed BCD word is a legal decimal digit.
    function automatic logic bcd_word_valid(input logic [NUM_DIGITS*BCD_W-1:0] w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (w[i*BCD_W +: BCD_W] > BCD_MAX_DIGIT) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter.
// Load priority: load_zero, then load, then inc, then dec.
module bcd_digit
    import bcd_counter4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             load_zero,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    output logic [BCD_W-1:0] q,
    output logic [BCD_W-1:0] q_next,
    output logic             carry_out,
    output logic             borrow_out
);

    bcd_t digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_zero) begin
            digit_d = '0;
        end else if (load) begin
            digit_d = load_val;
        end else if (inc) begin
            digit_d = (digit_q == BCD_MAX_DIGIT) ? '0 : digit_q + 4'd1;
        end else if (dec) begin
            digit_d = (digit_q == '0) ? BCD_MAX_DIGIT : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q          = digit_q;
    assign q_next     = digit_d;
    assign carry_out  = inc && (digit_q == BCD_MAX_DIGIT);
    assign borrow_out = dec && (digit_q == '0);

endmodule

// File: rtl/bcd_counter4.sv
// Four-digit up/down BCD counter with prescaler, wrap pulse and terminal-value flag.
// Wrap-around loads bypass the carry chain so a wrap is always applied as one whole value.
module bcd_counter4
    import bcd_counter4_pkg::*;
#(
    parameter int                            CLK_DIV   = 50000000,
    parameter logic [NUM_DIGITS*BCD_W-1:0]   MAX_COUNT = 16'h9675
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             dir,
    output logic [BCD_W-1:0] dig0,
    output logic [BCD_W-1:0] dig1,
    output logic [BCD_W-1:0] dig2,
    output logic [BCD_W-1:0] dig3,
    output logic             wrap,
    output logic             at_max
);

    localparam int unsigned      PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("bcd_counter4: CLK_DIV must be >= 1");
    end
    if (!bcd_word_valid(MAX_COUNT)) begin : g_bad_max_count
        $error("bcd_counter4: every MAX_COUNT nibble must be <= 9");
    end

    logic [PRE_W-1:0]              pre_q, pre_d;
    logic                          wrap_q, wrap_d;
    logic                          at_max_q, at_max_d;
    logic                          tick;
    logic                          at_max_now, is_zero, up_wrap, dn_wrap, load_zero;
    logic [NUM_DIGITS*BCD_W-1:0]   count_q, count_nxt;
    bcd_t                          dig_q   [NUM_DIGITS];
    bcd_t                          dig_nxt [NUM_DIGITS];
    logic                          carry   [NUM_DIGITS+1];
    logic                          borrow  [NUM_DIGITS+1];
    logic                          unused_chain;

    assign tick       = en && (pre_q == PRE_LAST);
    assign at_max_now = (count_q == MAX_COUNT);
    assign is_zero    = (count_q == '0);
    assign up_wrap    = tick && dir && at_max_now;
    assign dn_wrap    = tick && !dir && is_zero;
    assign load_zero  = clr || up_wrap;
    assign carry[0]   = tick && dir && !at_max_now;
    assign borrow[0]  = tick && !dir && !is_zero;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .inc        (carry[g]),
            .dec        (borrow[g]),
            .load_zero  (load_zero),
            .load       (dn_wrap),
            .load_val   (MAX_COUNT[g*BCD_W +: BCD_W]),
            .q          (dig_q[g]),
            .q_next     (dig_nxt[g]),
            .carry_out  (carry[g+1]),
            .borrow_out (borrow[g+1])
        );
    end

    // Carry or borrow out of the top digit cannot occur for counts <= MAX_COUNT.
    assign unused_chain = carry[NUM_DIGITS] ^ borrow[NUM_DIGITS];

    always_comb begin
        count_q   = '0;
        count_nxt = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            count_q[i*BCD_W +: BCD_W]   = dig_q[i];
            count_nxt[i*BCD_W +: BCD_W] = dig_nxt[i];
        end
    end

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
        end
    end

    assign wrap_d   = !clr && (up_wrap || dn_wrap);
    assign at_max_d = (clr || tick) ? (count_nxt == MAX_COUNT) : at_max_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q    <= '0;
            wrap_q   <= 1'b0;
            at_max_q <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            wrap_q   <= wrap_d;
            at_max_q <= at_max_d;
        end
    end

    assign dig0   = dig_q[0];
    assign dig1   = dig_q[1];
    assign dig2   = dig_q[2];
    assign dig3   = dig_q[3];
    assign wrap   = wrap_q;
    assign at_max = at_max_q;

endmodule

// File: tb/tb_bcd_counter4.sv
// Scoreboard bench for bcd_counter4: a decimal-integer model predicts every cycle,
// a monitor compares the DUT outputs against the queued predictions.
module tb_bcd_counter4;

    localparam int          ClkDiv   = 4;
    localparam logic [15:0] MaxCount = 16'h9675;
    localparam int          MaxDec   = 9675;

    logic       clk = 1'b0;
    logic       rst, en, clr, dir;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic       wrap, at_max;

    typedef struct packed {
        logic [15:0] digits;
        logic        wrap;
        logic        at_max;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    int   m_cnt   = 0;
    int   m_pre   = 0;
    logic m_wrap  = 1'b0;
    logic m_atmax = 1'b0;

    bcd_counter4 #(
        .CLK_DIV   (ClkDiv),
        .MAX_COUNT (MaxCount)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .clr    (clr),
        .dir    (dir),
        .dig0   (dig0),
        .dig1   (dig1),
        .dig2   (dig2),
        .dig3   (dig3),
        .wrap   (wrap),
        .at_max (at_max)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return 16'((v / 1000 % 10) * 4096 + (v / 100 % 10) * 256 + (v / 10 % 10) * 16 + v % 10);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the predicted result.
    task automatic step(input logic r, input logic e, input logic c, input logic d);
        logic was_rst;
        @(negedge clk);
        was_rst = rst;
        rst = r;
        en  = e;
        clr = c;
        dir = d;
        if (r) begin
            m_cnt = 0; m_pre = 0; m_wrap = 1'b0; m_atmax = 1'b0;
        end else if (c) begin
            m_cnt = 0; m_pre = 0; m_wrap = 1'b0; m_atmax = (MaxDec == 0);
        end else if (e) begin
            m_wrap = 1'b0;
            if (m_pre == ClkDiv - 1) begin
                m_pre = 0;
                if (d) begin
                    if (m_cnt == MaxDec) begin m_cnt = 0; m_wrap = 1'b1; end
                    else m_cnt++;
                end else begin
                    if (m_cnt == 0) begin m_cnt = MaxDec; m_wrap = 1'b1; end
                    else m_cnt--;
                end
                m_atmax = (m_cnt == MaxDec);
            end else begin
                m_pre++;
            end
        end else begin
            m_wrap = 1'b0;
        end
        sb_q.push_back('{digits: to_bcd(m_cnt), wrap: m_wrap, at_max: m_atmax});
        if (r && !was_rst) begin
            #1;
            check("async_rst", {dig3, dig2, dig1, dig0, wrap, at_max}, 32'd0);
        end
    endtask

    // Look at the outputs just after the edge that consumed the last step.
    task automatic look(input string name, input logic [15:0] want_d, input logic want_w);
        @(posedge clk);
        #2;
        check(name, {dig3, dig2, dig1, dig0}, want_d);
        check({name, "_wrap"}, wrap, want_w);
    endtask

    initial begin : monitor
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_digits", {dig3, dig2, dig1, dig0}, e.digits);
                check("sb_wrap", wrap, e.wrap);
                check("sb_at_max", at_max, e.at_max);
            end
        end
    end

    initial begin : stimulus
        logic r, e, c, d;
        rst = 1'b1; en = 1'b0; clr = 1'b0; dir = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);

        // Count up: first tick after 4 cycles, ones->tens carry after 40.
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            if (i == 4)  look("up_0001", 16'h0001, 1'b0);
            if (i == 40) look("up_0010", 16'h0010, 1'b0);
        end
        // Count down through 0000 to the terminal value.
        for (int i = 1; i <= 48; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 40) look("dn_0000", 16'h0000, 1'b0);
            if (i == 44) look("dn_wrap", 16'h9675, 1'b1);
            if (i == 48) look("dn_9674", 16'h9674, 1'b0);
        end
        // Up to MAX_COUNT then wrap to 0000.
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            if (i == 4) look("up_max", 16'h9675, 1'b0);
            if (i == 8) look("up_wrap", 16'h0000, 1'b1);
        end
        // Reset mid-count after 3 ticks and a partial prescale.
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            if (i == 3) look("rst_no_tick", 16'h0000, 1'b0);
            if (i == 4) look("rst_first_tick", 16'h0001, 1'b0);
        end
        // Clear coinciding with the tick that would leave 0009.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 39; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        look("clr_tick", 16'h0000, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            if (i == 3) look("clr_no_tick", 16'h0000, 1'b0);
            if (i == 4) look("clr_next_tick", 16'h0001, 1'b0);
        end
        // Enable gating holds the prescaler.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        look("en_hold", 16'h0001, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        look("en_resume", 16'h0002, 1'b0);

        // Randomized traffic, checked by the scoreboard.
        d = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 399) == 0);
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 63) == 0) d = ~d;
            step(r, e, c, d);
        end

        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        check("sb_drain", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
